// File: rtl/instruction_execute.sv
// Execute stage: ALU, branch/jump resolution with fetch redirect, and the EX/MEM pipeline register.
// A 2-bit squash counter kills the two younger instructions that follow a taken redirect.
module instruction_execute (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ID_EX_A,
    input  logic [31:0] ID_EX_B,
    input  logic [31:0] ID_EX_IMM,
    input  logic [31:0] ID_EX_PC,
    input  logic [4:0]  ID_EX_RD,
    input  logic [1:0]  alu_type_sel,
    input  logic [2:0]  alucontrol,
    input  logic [6:0]  alucontrol7,
    input  logic        b_imm_sel,
    input  logic        branch,
    input  logic        jump,
    input  logic        memwrite_en,
    input  logic        regwrite_en,
    input  logic        wb_sel,
    output logic        PC_sel,
    output logic [31:0] PCtarget,
    output logic [31:0] EX_MEM_ALU,
    output logic [31:0] EX_MEM_WD,
    output logic [31:0] EX_MEM_PC4,
    output logic [4:0]  EX_MEM_RD,
    output logic [2:0]  EX_MEM_funct3,
    output logic        EX_MEM_regwrite,
    output logic        EX_MEM_memwrite,
    output logic        EX_MEM_wb_sel,
    output logic        EX_MEM_link
);

    logic [31:0] op_b_s;
    logic [31:0] a_imm_s;
    logic [31:0] pc_imm_s;
    logic [31:0] pc4_s;
    logic [31:0] alu_s;
    logic [31:0] result_s;
    logic [4:0]  shamt_s;
    logic        taken_s;
    logic        live_s;
    logic [1:0]  sq_r;
    logic [1:0]  sq_next_s;
    logic        unused_funct7_s;

    assign unused_funct7_s = ^{alucontrol7[6], alucontrol7[4:0]};

    assign op_b_s   = b_imm_sel ? ID_EX_IMM : ID_EX_B;
    assign a_imm_s  = ID_EX_A + ID_EX_IMM;
    assign pc_imm_s = ID_EX_PC + ID_EX_IMM;
    assign pc4_s    = ID_EX_PC + 32'd4;
    assign shamt_s  = op_b_s[4:0];
    assign live_s   = (sq_r == 2'd0);

    // Integer ALU for alu_type_sel=00, keyed on funct3/funct7
    always_comb begin
        alu_s = 32'd0;
        case (alucontrol)
            3'b000: begin
                if (alucontrol7[5] && !b_imm_sel) begin
                    alu_s = ID_EX_A - op_b_s;
                end else begin
                    alu_s = ID_EX_A + op_b_s;
                end
            end
            3'b001: alu_s = ID_EX_A << shamt_s;
            3'b010: alu_s = ($signed(ID_EX_A) < $signed(op_b_s)) ? 32'd1 : 32'd0;
            3'b011: alu_s = (ID_EX_A < op_b_s) ? 32'd1 : 32'd0;
            3'b100: alu_s = ID_EX_A ^ op_b_s;
            3'b101: begin
                if (alucontrol7[5]) begin
                    alu_s = $unsigned($signed(ID_EX_A) >>> shamt_s);
                end else begin
                    alu_s = ID_EX_A >> shamt_s;
                end
            end
            3'b110: alu_s = ID_EX_A | op_b_s;
            3'b111: alu_s = ID_EX_A & op_b_s;
            default: alu_s = 32'd0;
        endcase
    end

    // Result selection: link value for jumps, address for memory ops, else by alu_type_sel
    always_comb begin
        result_s = 32'd0;
        if (jump) begin
            result_s = pc4_s;
        end else if (wb_sel || memwrite_en) begin
            result_s = a_imm_s;
        end else begin
            case (alu_type_sel)
                2'b00:   result_s = alu_s;
                2'b01:   result_s = ID_EX_IMM;
                2'b10:   result_s = pc_imm_s;
                2'b11:   result_s = a_imm_s;
                default: result_s = alu_s;
            endcase
        end
    end

    // Branch condition always compares against rs2, never the immediate
    always_comb begin
        taken_s = 1'b0;
        case (alucontrol)
            3'b000:  taken_s = (ID_EX_A == ID_EX_B);
            3'b001:  taken_s = (ID_EX_A != ID_EX_B);
            3'b100:  taken_s = ($signed(ID_EX_A) <  $signed(ID_EX_B));
            3'b101:  taken_s = ($signed(ID_EX_A) >= $signed(ID_EX_B));
            3'b110:  taken_s = (ID_EX_A <  ID_EX_B);
            3'b111:  taken_s = (ID_EX_A >= ID_EX_B);
            default: taken_s = 1'b0;
        endcase
    end

    // Redirect outputs and squash counter next state
    always_comb begin
        PC_sel = live_s && ((branch && taken_s) || jump);
        if (jump && (alu_type_sel == 2'b11)) begin
            PCtarget = {a_imm_s[31:1], 1'b0};
        end else begin
            PCtarget = pc_imm_s;
        end
        if (sq_r != 2'd0) begin
            sq_next_s = sq_r - 2'd1;
        end else if (PC_sel) begin
            sq_next_s = 2'd2;
        end else begin
            sq_next_s = 2'd0;
        end
    end

    // EX/MEM register: data always loads, control bits only for live instructions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_r            <= 2'd0;
            EX_MEM_ALU      <= 32'd0;
            EX_MEM_WD       <= 32'd0;
            EX_MEM_PC4      <= 32'd0;
            EX_MEM_RD       <= 5'd0;
            EX_MEM_funct3   <= 3'd0;
            EX_MEM_regwrite <= 1'b0;
            EX_MEM_memwrite <= 1'b0;
            EX_MEM_wb_sel   <= 1'b0;
            EX_MEM_link     <= 1'b0;
        end else begin
            sq_r            <= sq_next_s;
            EX_MEM_ALU      <= result_s;
            EX_MEM_WD       <= ID_EX_B;
            EX_MEM_PC4      <= pc4_s;
            EX_MEM_RD       <= ID_EX_RD;
            EX_MEM_funct3   <= alucontrol;
            EX_MEM_regwrite <= live_s && regwrite_en;
            EX_MEM_memwrite <= live_s && memwrite_en;
            EX_MEM_wb_sel   <= live_s && wb_sel;
            EX_MEM_link     <= live_s && jump;
        end
    end

endmodule

// File: tb/tb_instruction_execute.sv
// Randomized and directed bench for instruction_execute against a behavioural execute-stage model.
module tb_instruction_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_PC;
    logic [4:0]  ID_EX_RD;
    logic [1:0]  alu_type_sel;
    logic [2:0]  alucontrol;
    logic [6:0]  alucontrol7;
    logic        b_imm_sel, branch, jump, memwrite_en, regwrite_en, wb_sel;
    logic        PC_sel;
    logic [31:0] PCtarget, EX_MEM_ALU, EX_MEM_WD, EX_MEM_PC4;
    logic [4:0]  EX_MEM_RD;
    logic [2:0]  EX_MEM_funct3;
    logic        EX_MEM_regwrite, EX_MEM_memwrite, EX_MEM_wb_sel, EX_MEM_link;

    int checks = 0;
    int errors = 0;

    instruction_execute dut (
        .clk(clk), .rst(rst),
        .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_IMM(ID_EX_IMM), .ID_EX_PC(ID_EX_PC),
        .ID_EX_RD(ID_EX_RD), .alu_type_sel(alu_type_sel), .alucontrol(alucontrol),
        .alucontrol7(alucontrol7), .b_imm_sel(b_imm_sel), .branch(branch), .jump(jump),
        .memwrite_en(memwrite_en), .regwrite_en(regwrite_en), .wb_sel(wb_sel),
        .PC_sel(PC_sel), .PCtarget(PCtarget), .EX_MEM_ALU(EX_MEM_ALU), .EX_MEM_WD(EX_MEM_WD),
        .EX_MEM_PC4(EX_MEM_PC4), .EX_MEM_RD(EX_MEM_RD), .EX_MEM_funct3(EX_MEM_funct3),
        .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_memwrite(EX_MEM_memwrite),
        .EX_MEM_wb_sel(EX_MEM_wb_sel), .EX_MEM_link(EX_MEM_link)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_result();
        logic [31:0] a, b;
        a = ID_EX_A;
        b = b_imm_sel ? ID_EX_IMM : ID_EX_B;
        if (jump) return ID_EX_PC + 32'd4;
        if (wb_sel || memwrite_en) return a + ID_EX_IMM;
        if (alu_type_sel == 2'b01) return ID_EX_IMM;
        if (alu_type_sel == 2'b10) return ID_EX_PC + ID_EX_IMM;
        if (alu_type_sel == 2'b11) return a + ID_EX_IMM;
        case (alucontrol)
            3'd0: return (alucontrol7[5] && !b_imm_sel) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alucontrol7[5] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic m_taken();
        int signed sa, sb;
        sa = ID_EX_A;
        sb = ID_EX_B;
        case (alucontrol)
            3'd0: return ID_EX_A == ID_EX_B;
            3'd1: return ID_EX_A != ID_EX_B;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ID_EX_A < ID_EX_B;
            3'd7: return ID_EX_A >= ID_EX_B;
            default: return 1'b0;
        endcase
    endfunction

    int          m_kill;          // younger instructions still to be killed
    logic [31:0] e_alu, e_wd, e_pc4;
    logic [4:0]  e_rd;
    logic [2:0]  e_f3;
    logic        e_rw, e_mw, e_wb, e_link;

    function automatic logic m_pcsel();
        return (m_kill == 0) && ((branch && m_taken()) || jump);
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] t;
        if (jump && alu_type_sel == 2'b11) begin
            t = ID_EX_A + ID_EX_IMM;
            t[0] = 1'b0;
            return t;
        end
        return ID_EX_PC + ID_EX_IMM;
    endfunction

    // Model of the EX/MEM contents expected after each edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_kill <= 0;
            {e_alu, e_wd, e_pc4} <= '0;
            e_rd <= 5'd0; e_f3 <= 3'd0;
            {e_rw, e_mw, e_wb, e_link} <= 4'b0000;
        end else begin
            m_kill <= (m_kill > 0) ? m_kill - 1 : (m_pcsel() ? 2 : 0);
            e_alu  <= m_result();
            e_wd   <= ID_EX_B;
            e_pc4  <= ID_EX_PC + 32'd4;
            e_rd   <= ID_EX_RD;
            e_f3   <= alucontrol;
            e_rw   <= (m_kill == 0) && regwrite_en;
            e_mw   <= (m_kill == 0) && memwrite_en;
            e_wb   <= (m_kill == 0) && wb_sel;
            e_link <= (m_kill == 0) && jump;
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        check("pc_sel",   {31'd0, PC_sel}, {31'd0, m_pcsel()});
        check("pctarget", PCtarget, m_target());
        check("alu",      EX_MEM_ALU, e_alu);
        check("wd",       EX_MEM_WD, e_wd);
        check("pc4",      EX_MEM_PC4, e_pc4);
        check("rd",       {27'd0, EX_MEM_RD}, {27'd0, e_rd});
        check("funct3",   {29'd0, EX_MEM_funct3}, {29'd0, e_f3});
        check("ctl",      {28'd0, EX_MEM_regwrite, EX_MEM_memwrite, EX_MEM_wb_sel, EX_MEM_link},
                          {28'd0, e_rw, e_mw, e_wb, e_link});
    end

    // ---------------- stimulus ----------------
    task automatic clear_in();
        {ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_PC} = '0;
        ID_EX_RD = 5'd0; alu_type_sel = 2'b00; alucontrol = 3'd0; alucontrol7 = 7'd0;
        {b_imm_sel, branch, jump, memwrite_en, regwrite_en, wb_sel} = 6'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        clear_in();
        #3;
        check("rst_alu", EX_MEM_ALU, 32'd0);
        check("rst_ctl", {28'd0, EX_MEM_regwrite, EX_MEM_memwrite, EX_MEM_wb_sel, EX_MEM_link}, 32'd0);
        cyc();
        rst = 1'b1;

        // R-type sub
        ID_EX_A = 32'd5; ID_EX_B = 32'd7; alucontrol7 = 7'b0100000; regwrite_en = 1'b1; ID_EX_RD = 5'd3;
        cyc();
        check("sub_alu", EX_MEM_ALU, 32'hFFFFFFFE);
        check("sub_rw", {31'd0, EX_MEM_regwrite}, 32'd1);
        check("sub_rd", {27'd0, EX_MEM_RD}, 32'd3);

        // Arithmetic and logical shift right by immediate
        clear_in();
        ID_EX_A = 32'h80000000; ID_EX_IMM = 32'd4; b_imm_sel = 1'b1; alucontrol = 3'b101;
        alucontrol7 = 7'b0100000;
        cyc();
        check("sra", EX_MEM_ALU, 32'hF8000000);
        alucontrol7 = 7'b0000000;
        cyc();
        check("srl", EX_MEM_ALU, 32'h08000000);

        // BLT taken, then two squashed instructions, then a live one
        clear_in();
        ID_EX_A = 32'hFFFFFFFF; ID_EX_B = 32'd1; alucontrol = 3'b100; branch = 1'b1;
        ID_EX_PC = 32'h100; ID_EX_IMM = 32'h20;
        #1;
        check("blt_pcsel", {31'd0, PC_sel}, 32'd1);
        check("blt_target", PCtarget, 32'h120);
        cyc();
        for (int i = 0; i < 3; i++) begin
            clear_in();
            regwrite_en = 1'b1; ID_EX_RD = 5'd9; alucontrol = 3'b100; branch = 1'b1;
            ID_EX_A = 32'hFFFFFFFF; ID_EX_B = 32'd1;
            if (i == 2) branch = 1'b0;
            #1;
            if (i < 2) check("squash_pcsel", {31'd0, PC_sel}, 32'd0);
            cyc();
            check("squash_rw", {31'd0, EX_MEM_regwrite}, (i == 2) ? 32'd1 : 32'd0);
        end

        // JALR
        clear_in();
        ID_EX_A = 32'h1003; ID_EX_IMM = 32'd4; jump = 1'b1; alu_type_sel = 2'b11; ID_EX_PC = 32'h40;
        #1;
        check("jalr_target", PCtarget, 32'h1006);
        cyc();
        check("jalr_alu", EX_MEM_ALU, 32'h44);
        check("jalr_link", {31'd0, EX_MEM_link}, 32'd1);

        // Store, issued after the JALR shadow drains
        clear_in();
        cyc();
        cyc();
        memwrite_en = 1'b1; alucontrol = 3'b010; ID_EX_A = 32'h200; ID_EX_IMM = 32'hFFFFFFFC;
        ID_EX_B = 32'hDEADBEEF; b_imm_sel = 1'b1;
        cyc();
        check("st_alu", EX_MEM_ALU, 32'h1FC);
        check("st_wd", EX_MEM_WD, 32'hDEADBEEF);
        check("st_mw", {31'd0, EX_MEM_memwrite}, 32'd1);

        // Reset in the middle of a squash window
        clear_in();
        branch = 1'b1; ID_EX_PC = 32'h300; ID_EX_IMM = 32'h10;
        cyc();
        clear_in();
        rst = 1'b0;
        #1;
        check("mid_rst_alu", EX_MEM_ALU, 32'd0);
        check("mid_rst_pc4", EX_MEM_PC4, 32'd0);
        rst = 1'b1;
        regwrite_en = 1'b1; ID_EX_RD = 5'd4;
        cyc();
        check("post_rst_live", {31'd0, EX_MEM_regwrite}, 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            ID_EX_A   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
            ID_EX_B   = ($urandom_range(0, 3) == 0) ? ID_EX_A : $urandom;
            if ($urandom_range(0, 3) == 0) ID_EX_B = $urandom_range(0, 3);
            ID_EX_IMM = $urandom;
            ID_EX_PC  = $urandom;
            ID_EX_RD  = 5'($urandom);
            alu_type_sel = 2'($urandom);
            alucontrol   = 3'($urandom);
            alucontrol7  = ($urandom_range(0, 1) == 0) ? 7'b0100000 : 7'($urandom);
            b_imm_sel    = 1'($urandom);
            branch       = ($urandom_range(0, 3) == 0);
            jump         = ($urandom_range(0, 7) == 0) || (alu_type_sel == 2'b11);
            memwrite_en  = ($urandom_range(0, 7) == 0);
            wb_sel       = ($urandom_range(0, 7) == 0);
            regwrite_en  = 1'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
